// File: rtl/multiplier_4x3.sv
// multiplier_4x3: unsigned A*B, iterative shift-add with valid/ready handshakes.
// Define MULT_COMB_EN for a single-cycle AND-array product (IDLE->DONE directly).
module multiplier_4x3 #(
  parameter int A_W = 4,
  parameter int B_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] Y,
  output logic               busy
);

  localparam int Y_W = A_W + B_W;
  localparam int C_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [C_W-1:0] CNT_LAST = C_W'(B_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [Y_W-1:0] acc_q, acc_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W-1:0] addend;
`ifdef MULT_COMB_EN
  logic [Y_W-1:0] prod;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign Y         = y_q;

`ifdef MULT_COMB_EN
  // AND-array: sum of B_W gated, shifted copies of A
  always_comb begin
    prod = '0;
    for (int i = 0; i < B_W; i++) begin
      if (B[i]) prod = prod + (Y_W'(A) << i);
    end
  end
`endif

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    addend  = b_q[cnt_q] ? (Y_W'(a_q) << cnt_q) : '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          acc_d = '0;
          cnt_d = '0;
`ifdef MULT_COMB_EN
          y_d     = prod;
          state_d = DONE;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + C_W'(1);
        if (cnt_q == CNT_LAST) begin
          y_d     = acc_q + addend;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_multiplier_4x3.sv
// tb_multiplier_4x3: directed vectors with immediate assertions.
// Latency expectation follows the MULT_COMB_EN build switch.
module tb_multiplier_4x3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [2:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] Y;
  logic       busy;

  int n_cmp;
  int n_bad;

`ifdef MULT_COMB_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 3;
`endif

  multiplier_4x3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // edges after the acceptance edge until out_valid (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input logic [3:0] a, input logic [2:0] b,
                     input logic [6:0] exp, input string tag);
    int n;
    check({tag, "_in_ready"}, in_ready, 1);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_done(n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_y"}, Y, exp);
    tick();
    check({tag, "_idle"}, in_ready, 1);
    check({tag, "_hold"}, Y, exp);
  endtask

  initial begin
    int n;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    tick();
    tick();
    check("rst_y", Y, 0);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);

    run(4'd5, 3'd3, 7'd15, "p5x3");
    run(4'd15, 3'd5, 7'd75, "p15x5");
    run(4'd3, 3'd6, 7'd18, "p3x6");

    run(4'd0, 3'd7, 7'd0, "b0x7");
    run(4'd15, 3'd0, 7'd0, "b15x0");
    run(4'd15, 3'd7, 7'd105, "b15x7");
    run(4'd1, 3'd1, 7'd1, "b1x1");

    // backpressure: 9*2 = 18 held in DONE, new request ignored
    A         = 4'd9;
    B         = 3'd2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
`ifndef MULT_COMB_EN
    check("bp_busy", busy, 1);
`endif
    wait_done(n);
    check("bp_lat", n, LAT);
    A        = 4'd1;
    B        = 3'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_y", Y, 18);
      check("bp_ov", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_ov", out_valid, 0);
    check("bp_release_rdy", in_ready, 1);
    check("bp_release_y", Y, 18);

    // operand change after acceptance: 11*5 = 55
    A         = 4'd11;
    B         = 3'd5;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin
      A = 4'(n + 2);
      B = 3'(n + 1);
      tick();
      n++;
    end
    check("chg_lat", n, LAT);
    check("chg_y", Y, 55);
    tick();
    check("chg_idle", in_ready, 1);

    // reset on the 2nd CALC cycle aborts 6*7
    A        = 4'd6;
    B        = 3'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_y", Y, 0);
    check("abort_ov", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);

    run(4'd7, 3'd7, 7'd49, "p7x7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
